// File: rtl/anthem_stream_sequencer.sv
// anthem_stream_sequencer
//
// Walks a combinational message ROM one character at a time. Each character
// is offered to a downstream consumer over a valid/ready handshake. The block
// supports start, synchronous stop, looping and an optional inter-character gap.
//
// Optional feature macro: STREAM_PACE_EN
//   defined   -> GAP state and PACE_W down-counter are built; pace_div inserts
//                that many idle cycles after every non-final accept.
//   undefined -> no GAP state and no counter; pace_div is ignored.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              begin a message (honoured only when idle)
//   stop               synchronous abort from any state; wins over start
//   msg_sel[1:0]       message select, latched at start (00/11 -> 0, 01/10 -> 1)
//   loop               restart at index 0 after the last character
//   pace_div           gap cycles between characters (sampled at accept)
//   rom_msg, rom_addr  latched message id and character index to the ROM
//   rom_data           ROM byte, combinational from rom_msg/rom_addr
//   char_out           presented character, held until accepted
//   char_valid         char_out valid
//   char_ready         consumer accepts when high together with char_valid
//   busy               high in any state other than idle
//   done               one-cycle pulse when a non-looping message completes
module anthem_stream_sequencer #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned PACE_W = 16,
  parameter int unsigned LEN0   = 129,
  parameter int unsigned LEN1   = 77
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        msg_sel,
  input  logic              loop,
  input  logic [PACE_W-1:0] pace_div,
  output logic              rom_msg,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        char_out,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] Last0 = ADDR_W'(LEN0 - 1);
  localparam logic [ADDR_W-1:0] Last1 = ADDR_W'(LEN1 - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StFetch   = 2'd1,
`ifdef STREAM_PACE_EN
    StPresent = 2'd2,
    StGap     = 2'd3
`else
    StPresent = 2'd2
`endif
  } state_e;

  state_e              state_q, state_d;
  logic                msg_q, msg_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [7:0]          char_q, char_d;
  logic                valid_q, busy_q, done_q, done_d;
  logic [ADDR_W-1:0]   last_idx;
  logic                is_last;

`ifdef STREAM_PACE_EN
  logic [PACE_W-1:0]   gap_q, gap_d;
`else
  logic                unused_pace;
  assign unused_pace = ^pace_div;
`endif

  assign last_idx = msg_q ? Last1 : Last0;
  assign is_last  = (idx_q == last_idx);

  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    idx_d   = idx_q;
    char_d  = char_q;
    done_d  = 1'b0;
`ifdef STREAM_PACE_EN
    gap_d   = gap_q;
`endif
    if (stop) begin
      // Abort: index and last character are kept, nothing is signalled.
      state_d = StIdle;
`ifdef STREAM_PACE_EN
      gap_d   = '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            msg_d   = msg_sel[1] ^ msg_sel[0];
            idx_d   = '0;
            state_d = StFetch;
          end
        end
        StFetch: begin
          char_d  = rom_data;
          state_d = StPresent;
        end
        StPresent: begin
          if (char_ready) begin
            if (is_last && !loop) begin
              // Index stays on the last character while idle.
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              idx_d = is_last ? '0 : idx_q + 1'b1;
`ifdef STREAM_PACE_EN
              if (pace_div != '0) begin
                gap_d   = pace_div;
                state_d = StGap;
              end else begin
                state_d = StFetch;
              end
`else
              state_d = StFetch;
`endif
            end
          end
        end
`ifdef STREAM_PACE_EN
        StGap: begin
          // Leaving on a count of 1 makes the gap last exactly pace_div cycles.
          gap_d = gap_q - 1'b1;
          if (gap_q == PACE_W'(1)) begin
            state_d = StFetch;
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      msg_q   <= 1'b0;
      idx_q   <= '0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      idx_q   <= idx_d;
      char_q  <= char_d;
      valid_q <= (state_d == StPresent);
      busy_q  <= (state_d != StIdle);
      done_q  <= done_d;
    end
  end

`ifdef STREAM_PACE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end
`endif

  assign rom_msg    = msg_q;
  assign rom_addr   = idx_q;
  assign char_out   = char_q;
  assign char_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
